// File: rtl/uart_rx_host.sv
// Host-side 8-bit UART receiver (LSB first, 1 stop bit, idle-high) with a valid/ready byte output.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err; otherwise frames are 8N1.
module uart_rx_host #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned H  = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] HALF_LOAD = CW'(H - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] seen_q;
   logic                   rxd_s;
   logic                   armed;
   logic [CW-1:0]          cnt;
   logic [2:0]             bitn;
   logic [7:0]             shreg;
`ifdef UART_RX_PARITY_EN
   logic                   par_bad;
`endif

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         seen_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
         seen_q <= {seen_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];

   // armed only once a genuinely sampled high has reached rxd_s, so a line
   // still low when rst falls cannot start a frame without a fresh 1->0 edge
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         armed     <= 1'b0;
         cnt       <= '0;
         bitn      <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         if (seen_q[SYNC_STAGES-1] && rxd_s)
            armed <= 1'b1;

         case (state)
            IDLE: begin
               if (armed && !rxd_s) begin
                  state <= START;
                  cnt   <= HALF_LOAD;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rxd_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= DATA;
                  cnt   <= BIT_LOAD;
                  bitn  <= '0;
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shreg <= {rxd_s, shreg[7:1]};
                  cnt   <= BIT_LOAD;
                  bitn  <= bitn + 1'b1;
                  if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  par_bad <= rxd_s ^ (^shreg);
                  cnt     <= BIT_LOAD;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!rxd_s) begin
                  frame_err <= 1'b1;
                  state     <= WAIT_IDLE;
               end else begin
                  // back to IDLE at mid-stop-bit so the next start edge is not missed
                  state <= IDLE;
                  busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  if (par_bad)
                     parity_err <= 1'b1;
                  else
`endif
                  if (!rx_valid || rx_ready) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
            WAIT_IDLE: begin
               if (rxd_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_host.sv
// Self-checking bench for uart_rx_host: directed vector table, hand-written corner cases,
// and random frames checked against a byte-level reference model.
module tb_uart_rx_host;

   localparam int N   = 104;
   localparam int H   = N / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB  = 11;
   localparam bit PAR = 1'b1;
`else
   localparam int NB  = 10;
   localparam bit PAR = 1'b0;
`endif
   localparam int LAT = 2 + H + (NB - 1) * N + 1;

   logic       sysclk = 1'b0;
   logic       rst    = 1'b1;
   logic       rxd    = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun, busy;

   int n_chk  = 0;
   int n_pass = 0;

   uart_rx_host #(.CLKS_PER_BIT(N), .SYNC_STAGES(2)) dut (
      .sysclk(sysclk), .rst(rst), .rxd(rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [7:0] d;
      logic       stopb, pflip, rdy;
      logic       e_pre, e_at, e_post;
      logic [7:0] e_data;
      logic       e_fe, e_pe, e_ov;
   } vec_t;

   typedef struct {
      logic       v_pre, v_at, v_post;
      logic [7:0] d_at;
      int         n_fe, n_pe, n_ov, n_val;
   } res_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic add(input logic [7:0] d, input logic stopb, input logic pflip, input logic rdy,
                      input logic e_pre, input logic e_at, input logic e_post, input logic [7:0] e_data,
                      input logic e_fe, input logic e_pe, input logic e_ov);
      vec_t v;
      v.d = d; v.stopb = stopb; v.pflip = pflip; v.rdy = rdy;
      v.e_pre = e_pre; v.e_at = e_at; v.e_post = e_post; v.e_data = e_data;
      v.e_fe = e_fe; v.e_pe = e_pe; v.e_ov = e_ov;
      tbl.push_back(v);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge sysclk); #1;
         rxd = 1'b1;
      end
   endtask

   // drives one frame starting right after a clock edge, then `gap` cycles of idle_lvl
   task automatic run_frame(input logic [7:0] d, input logic stopb, input logic pflip,
                            input logic rdy, input int gap, input logic idle_lvl,
                            output res_t r);
      logic [10:0] bits;
      logic        pbit;
      pbit    = (^d) ^ pflip;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
      bits[9]  = pbit;
      bits[10] = stopb;
`else
      bits[9]  = stopb;
      bits[10] = pbit;
`endif
      r.v_pre = 1'b0; r.v_at = 1'b0; r.v_post = 1'b0; r.d_at = '0;
      r.n_fe = 0; r.n_pe = 0; r.n_ov = 0; r.n_val = 0;
      for (int c = 0; c < NB * N + gap; c++) begin
         @(posedge sysclk); #1;
         if (c == 0) rx_ready = rdy;
         rxd = (c < NB * N) ? bits[c / N] : idle_lvl;
         #1;
         if (c == LAT - 1) r.v_pre = rx_valid;
         if (c == LAT) begin
            r.v_at = rx_valid;
            r.d_at = rx_data;
         end
         if (c == LAT + 1) r.v_post = rx_valid;
         r.n_fe  += int'(frame_err);
         r.n_pe  += int'(parity_err);
         r.n_ov  += int'(overrun);
         r.n_val += int'(rx_valid);
      end
   endtask

   initial begin
      res_t r;
      logic m_held;
      logic [7:0] m_data;
      int nfe, npe, nov, nval;
      logic [7:0] d;
      logic stopb, pflip, rdy, e_pre, e_at, e_post, e_fe, e_pe, e_ov, clean;

      add(8'h55, 1, 0, 1,  0, 1, 0, 8'h55,  0, 0, 0);
      add(8'hA3, 0, 0, 1,  0, 0, 0, 8'h00,  1, 0, 0);
      add(8'h00, 1, 0, 1,  0, 1, 0, 8'h00,  0, 0, 0);
      add(8'hFF, 1, 0, 1,  0, 1, 0, 8'hFF,  0, 0, 0);
`ifdef UART_RX_PARITY_EN
      add(8'h07, 1, 1, 1,  0, 0, 0, 8'h00,  0, 1, 0);
      add(8'h07, 1, 0, 1,  0, 1, 0, 8'h07,  0, 0, 0);
`endif
      add(8'h01, 1, 0, 0,  0, 1, 1, 8'h01,  0, 0, 0);
      add(8'h02, 1, 0, 0,  1, 1, 1, 8'h01,  0, 0, 1);

      // reset state
      #3;
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      repeat (3) @(posedge sysclk);
      #1 rst = 1'b0;
      idle(10);

      foreach (tbl[i]) begin
         run_frame(tbl[i].d, tbl[i].stopb, tbl[i].pflip, tbl[i].rdy, 4, 1'b1, r);
         chk($sformatf("tbl%0d_pre", i), r.v_pre, tbl[i].e_pre);
         chk($sformatf("tbl%0d_valid", i), r.v_at, tbl[i].e_at);
         if (tbl[i].e_at) chk($sformatf("tbl%0d_data", i), r.d_at, tbl[i].e_data);
         chk($sformatf("tbl%0d_post", i), r.v_post, tbl[i].e_post);
         chk($sformatf("tbl%0d_ferr", i), r.n_fe, tbl[i].e_fe);
         chk($sformatf("tbl%0d_perr", i), r.n_pe, tbl[i].e_pe);
         chk($sformatf("tbl%0d_ovr", i), r.n_ov, tbl[i].e_ov);
      end

      // held 0x01 accepted once rx_ready rises
      chk("held_data", rx_data, 8'h01);
      @(posedge sysclk); #1 rx_ready = 1'b1;
      @(posedge sysclk); #2;
      chk("accept_valid", rx_valid, 0);

      // short low glitch rejected by the start-bit check
      nfe = 0; npe = 0; nov = 0; nval = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge sysclk); #1;
         rxd = (c < 40) ? 1'b0 : 1'b1;
         #1;
         if (c == 20) chk("glitch_busy_hi", busy, 1);
         if (c == 60) chk("glitch_busy_lo", busy, 0);
         nfe += int'(frame_err); npe += int'(parity_err); nov += int'(overrun); nval += int'(rx_valid);
      end
      chk("glitch_pulses", nfe + npe + nov, 0);
      chk("glitch_valid", nval, 0);

      // framing error followed by a long break, then recovery
      run_frame(8'hA3, 1'b0, 1'b0, 1'b1, 2000, 1'b0, r);
      chk("break_ferr", r.n_fe, 1);
      chk("break_other", r.n_pe + r.n_ov, 0);
      chk("break_valid", r.n_val, 0);
      chk("break_busy", busy, 1);
      idle(10);
      run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 4, 1'b1, r);
      chk("after_break_valid", r.v_at, 1);
      chk("after_break_data", r.d_at, 8'h3C);
      chk("after_break_ferr", r.n_fe, 0);

      // reset in the middle of data bit 3
      run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 4, 1'b1, r);
      chk("prerst_valid", r.v_at, 1);
      for (int c = 0; c < NB * N + 20; c++) begin
         @(posedge sysclk); #1;
         rxd = (c == 0 || c >= NB * N) ? 1'b1 : ((c < N) ? 1'b0 : 1'b1);
         if (c == 4 * N + H) begin
            chk("prerst_busy", busy, 1);
            chk("prerst_held", rx_valid, 1);
            rst = 1'b1;
            #1;
            chk("arst_valid", rx_valid, 0);
            chk("arst_data", rx_data, 0);
            chk("arst_busy", busy, 0);
            chk("arst_pulses", {frame_err, parity_err, overrun}, 0);
         end
         if (c == 4 * N + H + 5) rst = 1'b0;
      end
      rx_ready = 1'b1;
      run_frame(8'hC3, 1'b1, 1'b0, 1'b1, 4, 1'b1, r);
      chk("postrst_pre", r.v_pre, 0);
      chk("postrst_valid", r.v_at, 1);
      chk("postrst_data", r.d_at, 8'hC3);

      // random frames against the byte-level model
      m_held = 1'b0;
      m_data = '0;
      for (int k = 0; k < 24; k++) begin
         d     = 8'($urandom);
         stopb = ($urandom_range(0, 9) != 0);
         pflip = PAR ? 1'($urandom_range(0, 1)) : 1'b0;
         rdy   = 1'($urandom_range(0, 1));
         if (rdy) m_held = 1'b0;
         e_pre = m_held;
         e_fe  = !stopb;
         e_pe  = PAR && stopb && pflip;
         clean = stopb && !e_pe;
         e_ov  = clean && m_held;
         if (clean && !m_held) begin
            m_held = 1'b1;
            m_data = d;
         end
         e_at   = m_held;
         e_post = m_held && !rdy;
         run_frame(d, stopb, pflip, rdy, $urandom_range(2, 20), 1'b1, r);
         chk($sformatf("rnd%0d_pre", k), r.v_pre, e_pre);
         chk($sformatf("rnd%0d_valid", k), r.v_at, e_at);
         if (e_at) chk($sformatf("rnd%0d_data", k), r.d_at, m_data);
         chk($sformatf("rnd%0d_post", k), r.v_post, e_post);
         chk($sformatf("rnd%0d_ferr", k), r.n_fe, e_fe);
         chk($sformatf("rnd%0d_perr", k), r.n_pe, e_pe);
         chk($sformatf("rnd%0d_ovr", k), r.n_ov, e_ov);
         if (rdy) m_held = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
